// File: rtl/uart_tx_if.sv
// uart_tx_if: write handshake, status and serial line of the buffered UART transmitter
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    logic [7:0] pi_data;
    logic pi_flag;
    logic pi_ready;
    logic ovf_flag;
    logic tx;
    logic tx_busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    modport master (output pi_data, pi_flag, input pi_ready, ovf_flag, tx, tx_busy, fifo_level);
    modport slave (input pi_data, pi_flag, output pi_ready, ovf_flag, tx, tx_busy, fifo_level);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1/8N2 UART transmitter, byte FIFO feeding an LSB-first serializer
module uart_tx #(
    parameter int UART_BPS = 115200,
    parameter int CLK_FREQ = 100_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS = 1
) (
    input logic sys_clk,
    input logic sys_rst,
    uart_tx_if.slave bus
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int CW = BAUD_CNT_MAX > 1 ? $clog2(BAUD_CNT_MAX) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] level;
    logic tick, last_stop, push, pop, tx_r, busy_r, ovf_r;
    assign tick = cnt == CW'(BAUD_CNT_MAX - 1);
    assign last_stop = bit_cnt == 3'(STOP_BITS - 1);
    assign push = bus.pi_flag && bus.pi_ready;
    assign pop = level != '0 && (state == IDLE || (state == STOP && tick && last_stop));
    assign bus.pi_ready = level != LW'(FIFO_DEPTH);
    assign bus.fifo_level = level;
    assign bus.tx = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.ovf_flag = ovf_r;
    // bit_cnt wraps 7->0 on entering STOP and then counts stop bits
    always_comb begin
        state_n = state;
        cnt_n = (state == IDLE || tick) ? '0 : cnt + CW'(1);
        bit_n = bit_cnt;
        shift_n = shift;
        unique case (state)
            IDLE: if (pop) begin
                state_n = START;
                shift_n = mem[rp];
                bit_n = '0;
            end
            START: if (tick) state_n = DATA;
            DATA: if (tick) begin
                shift_n = shift >> 1;
                bit_n = bit_cnt + 3'd1;
                state_n = bit_cnt == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                bit_n = bit_cnt + 3'd1;
                if (last_stop) begin
                    state_n = pop ? START : IDLE;
                    shift_n = pop ? mem[rp] : shift;
                    bit_n = '0;
                end
            end
        endcase
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
            cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
            wp <= '0;
            rp <= '0;
            level <= '0;
            tx_r <= 1'b1;
            busy_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_cnt <= bit_n;
            shift <= shift_n;
            wp <= push ? wp + AW'(1) : wp;
            rp <= pop ? rp + AW'(1) : rp;
            level <= level + LW'(push) - LW'(pop);
            tx_r <= state == DATA ? shift[0] : state != START;
            busy_r <= state != IDLE;
            ovf_r <= bus.pi_flag && !bus.pi_ready;
        end
    end
    always_ff @(posedge sys_clk)
        if (push) mem[wp] <= bus.pi_data;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: random and directed stimulus on 8N1 and 8N2 transmitters checked cycle by cycle against a frame-timing model
module tb_uart_tx;
    localparam int B = 10;
    localparam int DEPTH = 16;
    logic clk, rst, f;
    logic [7:0] d;
    int total, bad, busy_cnt;
    uart_tx_if #(.FIFO_DEPTH(DEPTH)) u0 ();
    uart_tx_if #(.FIFO_DEPTH(DEPTH)) u1 ();
    assign u0.pi_data = d;
    assign u0.pi_flag = f;
    assign u1.pi_data = d;
    assign u1.pi_flag = f;
    uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .FIFO_DEPTH(DEPTH), .STOP_BITS(1))
        dut0 (.sys_clk(clk), .sys_rst(rst), .bus(u0));
    uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .FIFO_DEPTH(DEPTH), .STOP_BITS(2))
        dut1 (.sys_clk(clk), .sys_rst(rst), .bus(u1));
    logic [7:0] q[2][$];
    bit active[2];
    int pos[2];
    logic [7:0] cur[2];
    logic etx[2], ebusy[2], eovf[2];
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask
    function automatic int flen(int i);
        return (10 + i) * B;
    endfunction
    function automatic logic line(int p, logic [7:0] b);
        int k = p / B;
        return k == 0 ? 1'b0 : k <= 8 ? b[k-1] : 1'b1;
    endfunction
    // pos counts cycles since the pop; the tx pin shows the line value one cycle late
    task automatic model_edge(int i);
        bit full, endf, popnow;
        if (rst) begin
            q[i].delete();
            active[i] = 0;
            etx[i] = 1;
            ebusy[i] = 0;
            eovf[i] = 0;
            return;
        end
        etx[i] = active[i] ? line(pos[i], cur[i]) : 1'b1;
        ebusy[i] = active[i];
        full = q[i].size() == DEPTH;
        eovf[i] = f && full;
        endf = active[i] && pos[i] == flen(i) - 1;
        popnow = q[i].size() > 0 && (!active[i] || endf);
        if (active[i]) pos[i]++;
        if (endf) active[i] = 0;
        if (popnow) begin
            cur[i] = q[i].pop_front();
            active[i] = 1;
            pos[i] = 0;
        end
        if (f && !full) q[i].push_back(d);
    endtask
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_edge(i);
        #1;
        check("tx0", u0.tx, etx[0]);
        check("busy0", u0.tx_busy, ebusy[0]);
        check("ovf0", u0.ovf_flag, eovf[0]);
        check("level0", u0.fifo_level, q[0].size());
        check("ready0", u0.pi_ready, q[0].size() != DEPTH);
        check("tx1", u1.tx, etx[1]);
        check("busy1", u1.tx_busy, ebusy[1]);
        check("ovf1", u1.ovf_flag, eovf[1]);
        check("level1", u1.fifo_level, q[1].size());
        check("ready1", u1.pi_ready, q[1].size() != DEPTH);
        if (u0.tx_busy) busy_cnt++;
    end
    task automatic wr(logic [7:0] v);
        f = 1;
        d = v;
        @(negedge clk);
        f = 0;
    endtask
    task automatic drain();
        int c = 0;
        while ((active[0] || active[1] || q[0].size() > 0 || q[1].size() > 0) && c < 6000) begin
            @(negedge clk);
            c++;
        end
        check("drain", c < 6000, 1);
        repeat (5) @(negedge clk);
    endtask
    initial begin
        int c;
        rst = 1;
        f = 0;
        d = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        busy_cnt = 0;
        wr(8'h55);
        @(negedge clk);
        check("fall_late", u0.tx, 1);
        @(negedge clk);
        check("fall", u0.tx, 0);
        repeat (120) @(negedge clk);
        check("busy_len0", busy_cnt, 10 * B);
        drain();
        for (int k = 0; k < 4; k++) wr(k == 0 ? 8'h00 : k == 1 ? 8'hFF : k == 2 ? 8'hA3 : 8'h3C);
        drain();
        for (int k = 0; k < 18; k++) begin
            f = 1;
            d = 8'($urandom);
            @(negedge clk);
        end
        f = 0;
        c = 0;
        while (!(active[0] && pos[0] == flen(0) - 1) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("pop_edge_wait", c < 500, 1);
        check("full_before_pop", q[0].size(), DEPTH);
        wr(8'hEE);
        drain();
        wr(8'hF0);
        c = 0;
        while (!(active[0] && pos[0] == 5 * B + B / 2) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("bit4_wait", c < 500, 1);
        wr(8'h11);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("rst_tx", u0.tx, 1);
        check("rst_level", u0.fifo_level, 0);
        repeat (150) @(negedge clk);
        for (int k = 0; k < 2; k++) wr(8'h81);
        drain();
        for (int k = 0; k < 4000; k++) begin
            f = $urandom_range(0, 29) == 0;
            d = 8'($urandom);
            rst = $urandom_range(0, 1499) == 0;
            @(negedge clk);
        end
        f = 0;
        rst = 0;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
